// File: rtl/div_pkg.sv
// Shared definitions for the arbitrated restoring divider.
package div_pkg;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division iteration, quotient bits MSB first.
module restoring_div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Shift {rem, quo} left, try subtracting b, restore when the trial goes negative.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - {1'b0, b};
    rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/div_arbiter_ctrl.sv
// Round-robin arbiter in front of a single iterative restoring divider.
module div_arbiter_ctrl
  import div_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [id_width(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]          rsp_quo,
  output logic [WIDTH-1:0]          rsp_rem,
  output logic                      rsp_dbz,
  output logic                      busy
);

  localparam int unsigned IDW = id_width(NREQ);
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [IDW-1:0]   last_grant, grant_id, idx;
  logic             grant_any, accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] b_q, rem_q, quo_q, rem_step, quo_step;
  logic [IDW-1:0]   id_q;
  logic             dbz_q;
  logic [CW-1:0]    cnt_q;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .b        (b_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Pick the first valid requester scanning upward from last_grant+1.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(last_grant) + 1 + k) % NREQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // Route the winner's operands to the capture registers.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant is only offered while idle.
  always_comb begin
    req_ready = '0;
    accept    = (state == IDLE) && grant_any;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = (sel_b == '0) ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand capture, iteration and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(NREQ - 1);
      id_q       <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dbz_q      <= 1'b0;
      cnt_q      <= '0;
    end else if (accept) begin
      last_grant <= grant_id;
      id_q       <= grant_id;
      b_q        <= sel_b;
      cnt_q      <= CW'(WIDTH - 1);
      if (sel_b == '0) begin
        quo_q <= '1;
        rem_q <= sel_a;
        dbz_q <= 1'b1;
      end else begin
        quo_q <= sel_a;
        rem_q <= '0;
        dbz_q <= 1'b0;
      end
    end else if (state == CALC) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_id    = id_q;
  assign rsp_quo   = quo_q;
  assign rsp_rem   = rem_q;
  assign rsp_dbz   = dbz_q;

endmodule

// File: tb/tb_div_arbiter_ctrl.sv
// Directed and randomized checks of div_arbiter_ctrl against a behavioural model.
module tb_div_arbiter_ctrl;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_quo, rsp_rem;
  logic        rsp_dbz, busy;

  int checks = 0;
  int errors = 0;
  int ptr    = NREQ - 1;   // model of the round-robin pointer

  div_arbiter_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_quo   (rsp_quo),
    .rsp_rem   (rsp_rem),
    .rsp_dbz   (rsp_dbz),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset(input logic [3:0] hold_valid);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = hold_valid;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr   = NREQ - 1;
  endtask

  // One full transaction: grant, latency, result, optional backpressure, handshake.
  task automatic run_txn(input logic [3:0] mask, input logic [15:0] av,
                         input logic [15:0] bv, input int stall);
    int win, n, exp_lat;
    logic [3:0] a, b, eq, er;
    logic edbz;
    @(negedge clk);
    req_valid = mask;
    req_a     = av;
    req_b     = bv;
    rsp_ready = 1'b0;
    win = rr_pick(mask, ptr);
    a = 4'(av >> (win * WIDTH));
    b = 4'(bv >> (win * WIDTH));
    if (b == 0) begin eq = 4'hF; er = a; edbz = 1'b1; exp_lat = 1; end
    else begin eq = a / b; er = a % b; edbz = 1'b0; exp_lat = WIDTH + 1; end
    #1;
    check("grant", req_ready, 32'(1) << win);
    @(posedge clk);
    ptr = win;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check("busy_op", busy, 1);
      check("ready_op", req_ready, 0);
    end while (!rsp_valid && n < 40);
    check("latency", n, exp_lat);
    check("rsp_id", rsp_id, win);
    check("rsp_quo", rsp_quo, eq);
    check("rsp_rem", rsp_rem, er);
    check("rsp_dbz", rsp_dbz, edbz);
    if (b != 0) check("identity", rsp_quo * b + rsp_rem, a);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_id", rsp_id, win);
      check("hold_quo", rsp_quo, eq);
      check("hold_rem", rsp_rem, er);
      check("hold_dbz", rsp_dbz, edbz);
      check("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
    check("ready_after_hs", req_ready, 32'(1) << rr_pick(mask, ptr));
    req_valid = '0;
  endtask

  initial begin
    int gid[5];
    int gcyc[5];
    int ng;
    logic seen;
    logic [15:0] av, bv;
    logic [3:0] m;

    // Asynchronous reset state
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quo", rsp_quo, 0);
    check("rst_rem", rsp_rem, 0);
    check("rst_id", rsp_id, 0);
    check("rst_dbz", rsp_dbz, 0);
    check("rst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr = NREQ - 1;

    // Single divide on requester 2: 13 / 3
    av = 16'($urandom); bv = 16'($urandom);
    av[11:8] = 4'd13; bv[11:8] = 4'd3;
    run_txn(4'b0100, av, bv, 0);

    // Divide by zero on requester 0: 9 / 0
    av = 16'($urandom); bv = 16'($urandom);
    av[3:0] = 4'd9; bv[3:0] = 4'd0;
    run_txn(4'b0001, av, bv, 0);

    // Backpressure for 10 cycles
    run_txn(4'b1010, 16'($urandom), 16'($urandom), 10);

    // Fairness with every requester continuously valid
    req_a = 16'($urandom);
    for (int i = 0; i < NREQ; i++) req_b[i*4 +: 4] = 4'($urandom_range(1, 15));
    do_reset(4'b1111);
    rsp_ready = 1'b1;
    ng = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (req_ready != 0 && ng < 5) begin
        gid[ng] = $clog2(int'(req_ready));
        gcyc[ng] = cyc;
        ng++;
      end
      @(negedge clk);
    end
    check("fair_count", ng, 5);
    for (int k = 0; k < ng; k++) begin
      check("fair_order", gid[k], k % NREQ);
      if (k > 0) check("fair_spacing", gcyc[k] - gcyc[k-1], 6);
    end

    // Reset during the second CALC cycle
    do_reset(4'b0000);
    req_valid = 4'b0100;
    req_b = 16'h3333;
    req_a = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("midrst_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_quo", rsp_quo, 0);
    check("midrst_rem", rsp_rem, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr = NREQ - 1;
    #1;
    check("midrst_first_grant", req_ready, 4'b0001);
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("midrst_no_rsp", seen, 0);

    // Exhaustive operand sweep through requester 0
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        av = 16'($urandom); bv = 16'($urandom);
        av[3:0] = 4'(a); bv[3:0] = 4'(b);
        run_txn(4'b0001, av, bv, 0);
      end
    end

    // Randomized mixed traffic
    for (int t = 0; t < 120; t++) begin
      m = 4'($urandom_range(1, 15));
      run_txn(m, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
